// File: rtl/adc_align_ctl.sv
// adc_align_ctl: per-lane link-training sequencer for a 6-bit DDR ADC lane.
// Drives IODELAY calibrate/reset/increment and ISERDES bitslip. It locks word
// framing on PATTERN, scans delay taps for the first contiguous good run, then
// parks the delay at the centre of that run.
// Optional feature macro: ADC_ALIGN_MONITOR_EN (pattern-error monitor in LOCK).
module adc_align_ctl #(
  parameter logic [5:0]  PATTERN = 6'b111000,
  parameter int unsigned SETTLE  = 8,
  parameter int unsigned NSAMP   = 16,
  parameter int unsigned MAXTAP  = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [5:0] i_dout,
  input  logic       i_busy,
  output logic       o_bs,
  output logic       o_dcal,
  output logic       o_drst,
  output logic       o_dinc,
  output logic       o_done,
  output logic       o_err,
  output logic [7:0] o_tap,
  output logic [2:0] o_slips
);

  // state     | meaning
  // S_IDLE    | inactive, waiting for START (ERR may be held)
  // S_CAL_RISE| DCAL issued, waiting up to 4 cycles for BUSY to rise
  // S_CAL_FALL| waiting for calibration BUSY to fall
  // S_RSTD    | DRST issued, waiting for BUSY low before the framing search
  // S_SLIP    | counting consecutive PATTERN words, bitslip on mismatch
  // S_SCAN    | qualifying one tap per pass, DINC between taps
  // S_CTR_RST | DRST issued for centring, waiting for BUSY low
  // S_CTR_INC | issuing DINC pulses two cycles apart up to the centre tap
  // S_CTR_SET | final settle before reporting lock
  // S_LOCK    | aligned, DONE held
  typedef enum logic [3:0] {
    S_IDLE, S_CAL_RISE, S_CAL_FALL, S_RSTD, S_SLIP,
    S_SCAN, S_CTR_RST, S_CTR_INC, S_CTR_SET, S_LOCK
  } state_t;

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);
  localparam logic [7:0] NSAMP_M1 = 8'(NSAMP - 1);
  localparam logic [7:0] MAXTAP_C = 8'(MAXTAP);

  state_t     r_state, w_state;
  logic       r_bs, r_dcal, r_drst, r_dinc, r_done, r_err;
  logic       w_bs, w_dcal, w_drst, w_dinc, w_done, w_err;
  logic [7:0] r_tap, w_tap;
  logic [2:0] r_slips, w_slips;
  logic [7:0] r_cnt, w_cnt;
  logic [7:0] r_match, w_match;
  logic [7:0] r_first, w_first, r_last, w_last, r_rem, w_rem;
  logic       r_found, w_found, r_gap, w_gap;
  logic [8:0] w_sum;
  logic       w_hit;
`ifdef ADC_ALIGN_MONITOR_EN
  logic [7:0] r_mon, w_mon;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state = r_state;
    w_bs    = 1'b0;
    w_dcal  = 1'b0;
    w_drst  = 1'b0;
    w_dinc  = 1'b0;
    w_done  = r_done;
    w_err   = r_err;
    w_tap   = r_tap;
    w_slips = r_slips;
    w_cnt   = r_cnt;
    w_match = r_match;
    w_first = r_first;
    w_last  = r_last;
    w_found = r_found;
    w_gap   = r_gap;
    w_rem   = r_rem;
    w_sum   = {1'b0, r_first} + {1'b0, r_last};
    w_hit   = (i_dout == PATTERN);
`ifdef ADC_ALIGN_MONITOR_EN
    w_mon   = r_mon;
`endif
    if (i_start) begin
      w_state = S_CAL_RISE;
      w_dcal  = 1'b1;
      w_done  = 1'b0;
      w_err   = 1'b0;
      w_tap   = '0;
      w_slips = '0;
      w_cnt   = 8'd3;
      w_match = '0;
      w_first = '0;
      w_last  = '0;
      w_found = 1'b0;
      w_gap   = 1'b0;
      w_rem   = '0;
`ifdef ADC_ALIGN_MONITOR_EN
      w_mon   = '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_CAL_RISE: begin
          if (i_busy || r_cnt == 8'd0) w_state = S_CAL_FALL;
          else w_cnt = r_cnt - 8'd1;
        end
        S_CAL_FALL: begin
          if (!i_busy) begin
            w_drst  = 1'b1;
            w_tap   = '0;
            w_state = S_RSTD;
          end
        end
        S_RSTD: begin
          if (!i_busy) begin
            w_cnt   = SETTLE_C;
            w_match = '0;
            w_state = S_SLIP;
          end
        end
        S_SLIP: begin
          if (i_busy) begin
            w_cnt   = SETTLE_C;
            w_match = '0;
          end else if (r_cnt != 8'd0) begin
            w_cnt = r_cnt - 8'd1;
          end else if (w_hit) begin
            if (r_match == NSAMP_M1) begin
              w_state = S_SCAN;
              w_cnt   = SETTLE_C;
              w_match = '0;
            end else begin
              w_match = r_match + 8'd1;
            end
          end else begin
            // A sixth slip brings the word back to its original framing;
            // SLIPS stays at its cap of 5 and training fails.
            w_bs    = 1'b1;
            w_cnt   = SETTLE_C;
            w_match = '0;
            if (r_slips == 3'd5) begin
              w_err   = 1'b1;
              w_state = S_IDLE;
            end else begin
              w_slips = r_slips + 3'd1;
            end
          end
        end
        S_SCAN: begin
          if (i_busy) begin
            w_cnt   = SETTLE_C;
            w_match = '0;
          end else if (r_cnt != 8'd0) begin
            w_cnt = r_cnt - 8'd1;
          end else if (w_hit && r_match != NSAMP_M1) begin
            w_match = r_match + 8'd1;
          end else begin
            // Verdict for this tap: a miss marks it bad at once.
            w_match = '0;
            w_cnt   = SETTLE_C;
            if (w_hit) begin
              if (!r_found) w_first = r_tap;
              w_found = 1'b1;
              w_last  = r_tap;
            end
            if (w_hit ? (r_tap == MAXTAP_C) : r_found) begin
              w_drst  = 1'b1;
              w_tap   = '0;
              w_state = S_CTR_RST;
            end else if (r_tap == MAXTAP_C) begin
              w_err   = 1'b1;
              w_state = S_IDLE;
            end else begin
              w_dinc = 1'b1;
              w_tap  = r_tap + 8'd1;
            end
          end
        end
        S_CTR_RST: begin
          if (!i_busy) begin
            w_rem   = 8'(w_sum >> 1);
            w_gap   = 1'b0;
            w_state = S_CTR_INC;
          end
        end
        S_CTR_INC: begin
          if (i_busy) begin
            w_gap = r_gap;
          end else if (r_gap) begin
            w_gap = 1'b0;
          end else if (r_rem == 8'd0) begin
            w_cnt   = SETTLE_C;
            w_state = S_CTR_SET;
          end else begin
            w_dinc = 1'b1;
            w_tap  = r_tap + 8'd1;
            w_rem  = r_rem - 8'd1;
            w_gap  = 1'b1;
          end
        end
        S_CTR_SET: begin
          if (i_busy) begin
            w_cnt = SETTLE_C;
          end else if (r_cnt != 8'd0) begin
            w_cnt = r_cnt - 8'd1;
          end else begin
            w_done  = 1'b1;
            w_state = S_LOCK;
          end
        end
        S_LOCK: begin
`ifdef ADC_ALIGN_MONITOR_EN
          if (!w_hit && r_mon != 8'hFF) w_mon = r_mon + 8'd1;
          if (w_mon >= 8'd16) w_err = 1'b1;
`endif
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  // State and output registers; reset aborts any training immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_bs    <= 1'b0;
      r_dcal  <= 1'b0;
      r_drst  <= 1'b0;
      r_dinc  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_tap   <= '0;
      r_slips <= '0;
      r_cnt   <= '0;
      r_match <= '0;
      r_first <= '0;
      r_last  <= '0;
      r_found <= 1'b0;
      r_gap   <= 1'b0;
      r_rem   <= '0;
`ifdef ADC_ALIGN_MONITOR_EN
      r_mon   <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_bs    <= w_bs;
      r_dcal  <= w_dcal;
      r_drst  <= w_drst;
      r_dinc  <= w_dinc;
      r_done  <= w_done;
      r_err   <= w_err;
      r_tap   <= w_tap;
      r_slips <= w_slips;
      r_cnt   <= w_cnt;
      r_match <= w_match;
      r_first <= w_first;
      r_last  <= w_last;
      r_found <= w_found;
      r_gap   <= w_gap;
      r_rem   <= w_rem;
`ifdef ADC_ALIGN_MONITOR_EN
      r_mon   <= w_mon;
`endif
    end
  end

  assign o_bs    = r_bs;
  assign o_dcal  = r_dcal;
  assign o_drst  = r_drst;
  assign o_dinc  = r_dinc;
  assign o_done  = r_done;
  assign o_err   = r_err;
  assign o_tap   = r_tap;
  assign o_slips = r_slips;

endmodule

// File: doc/adc_align_ctl.md
Name: adc_align_ctl

Overview:
Per-lane link-training sequencer for one 6-bit DDR ADC receive lane.
- Drives the lane's IODELAY controls (DCAL, DRST, DINC) and the ISERDES bitslip (BS).
- Locks word framing onto a fixed training pattern, then scans delay taps to find the valid-data eye and parks the delay at the eye centre.
- Instantiated once per ADC data lane, beside the receiver, in the same CLK domain.

Parameters:
PATTERN, 6'b111000, training word expected on DOUT once framing is correct.
SETTLE, 8, cycles to wait after any BS/DINC pulse or BUSY fall before sampling DOUT (1-255).
NSAMP, 16, consecutive matching words that mark a tap or framing as good (1-255).
MAXTAP, 255, highest tap index scanned (1-255).

Ports:
CLK     in   1  fabric clock; the receiver's CLK.
RST     in   1  asynchronous, active-high reset.
START   in   1  one-cycle pulse; begins training from any state.
DOUT    in   6  deserialized word from the lane receiver.
BUSY    in   1  IODELAY busy after CAL/RST.
BS      out  1  bitslip pulse to ISERDES.
DCAL    out  1  IODELAY calibrate pulse.
DRST    out  1  IODELAY reset pulse; delay returns to 0.
DINC    out  1  IODELAY increment pulse; drives CE and INC together.
DONE    out  1  training finished and lane aligned.
ERR     out  1  training failed.
TAP     out  8  delay tap currently applied.
SLIPS   out  3  bitslips applied since START (0-5).

Behaviour:
- Reset: all outputs 0; state IDLE. RST asserted mid-training aborts at once; no pulse completes.
- All output pulses are exactly 1 CLK wide and registered. Only one of BS/DCAL/DRST/DINC is high in any cycle.
- START in any state: clear DONE, ERR, TAP, SLIPS and all counters; go to CAL on the next cycle.
- CAL: pulse DCAL. Wait for BUSY to rise (at most 4 cycles; if it never rises, proceed anyway), then wait for BUSY=0. Go to RSTD.
- RSTD: pulse DRST; TAP<=0. Wait for BUSY=0, then SETTLE cycles. Go to SLIP.
- SLIP: count consecutive DOUT==PATTERN cycles.
  - Count reaches NSAMP: go to SCAN.
  - Any mismatch: pulse BS, SLIPS+1, wait SETTLE, restart the count.
  - Mismatch when SLIPS==5: ERR=1, go to IDLE.
- SCAN: for each tap t from TAP to MAXTAP:
  - Wait SETTLE, then sample NSAMP words. The tap is good iff all of them equal PATTERN.
  - Record FIRST = first good tap. LAST = last good tap of the first contiguous good run.
  - The scan ends at the first bad tap after a good run, or after testing MAXTAP.
  - Otherwise pulse DINC, TAP+1, next tap.
  - No good tap found: ERR=1, go to IDLE.
- CENTER: C = (FIRST+LAST)>>1, computed in 9-bit arithmetic and truncated to 8 bits. Pulse DRST (TAP<=0), wait BUSY=0, then pulse DINC C times, 2 cycles apart, TAP+1 each. Wait SETTLE, go to LOCK.
- LOCK: DONE=1; hold all control outputs 0 until START or RST.
- BUSY high in SLIP/SCAN/CENTER: freeze sampling and pulses until BUSY falls, then restart the SETTLE wait.
- TAP never exceeds MAXTAP. The IODELAY is in wrap-around mode, so no DINC is ever issued at TAP==MAXTAP.

Optional Feature:
ADC_ALIGN_MONITOR_EN
- Defined: in LOCK, a DOUT!=PATTERN word increments an 8-bit saturating error count. The count resets on START. ERR is asserted (DONE stays 1) once the count reaches 16. Use only while the ADC is sending the test pattern.
- Undefined: no monitor logic. In LOCK, DOUT is ignored and ERR stays 0.

Test Plan:
- Lane model with correct framing and good taps 20..40; START -> DCAL once, DRST twice, SLIPS=0, DONE=1, TAP=30, ERR=0.
- Model rotated by 3 bits, good taps 0..10 -> exactly 3 BS pulses, SLIPS=3, TAP=5, DONE=1.
- Model never matches under any rotation -> 6 BS pulses, then ERR=1, DONE=0, state IDLE.
- Good taps 100..255 with MAXTAP=255 -> scan stops at 255 with no DINC issued there, TAP=177, DONE=1.
- RST asserted mid-SCAN at tap 50 -> all outputs 0 the next cycle. A following START retrains cleanly to the expected TAP.
- BUSY held high 20 cycles during CAL, and a second START mid-CENTER -> no pulses while BUSY high; second START restarts from CAL with counters cleared.
